// File: rtl/peripheral_uart_tx_fifo.sv
// peripheral_uart_tx_fifo
//   UART transmit channel with a DEPTH-entry character FIFO, programmable
//   frame format (5..8 data bits, optional even/odd parity, 1 or 2 stop bits)
//   and a baud divisor (bit period = div_i+1 clock cycles).
//
// Ports
//   CLK, RSTN             clock, asynchronous active-low reset
//   wr_valid_i/wr_data_i  character write request / data
//   wr_ready_o            FIFO not full
//   en_i                  transmit enable (checked only between frames)
//   flush_i               synchronous FIFO clear; a running frame completes
//   div_i                 baud divisor
//   bits_i                character length code (0..3 -> 5..8 bits)
//   par_en_i, par_odd_i   parity present / odd parity
//   stop2_i               two stop bits
//   thr_i                 low-watermark level for event_o
//   tx_o                  registered serial output, idle high
//   busy_o                frame in progress
//   count_o               FIFO occupancy
//   event_o               one-cycle pulse after a pop that lands on thr_i
//
// state  | meaning
// IDLE   | line high, waiting for enable and a queued character
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when latched parity enable is set)
// STOP   | one or two stop bits (high)
module peripheral_uart_tx_fifo #(
  parameter  int DEPTH     = 16,
  parameter  int DIV_WIDTH = 16,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 wr_valid_i,
  input  logic [7:0]           wr_data_i,
  output logic                 wr_ready_o,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           bits_i,
  input  logic                 par_en_i,
  input  logic                 par_odd_i,
  input  logic                 stop2_i,
  input  logic [CW-1:0]        thr_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic [CW-1:0]        count_o,
  output logic                 event_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_d;

  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic                 full, push, pop, start_ok;
  logic [7:0]           head_m;
  logic [CW:0]          thr_p1;

  logic [DIV_WIDTH-1:0] tmr, div_q;
  logic                 bit_end;
  logic [7:0]           sh;
  logic [2:0]           bits_left;
  logic [1:0]           len_q;
  logic                 par_en_q, par_q, stop2_q, stop_left;
  logic                 tx_q, event_q;

  assign full       = (count == CW'(DEPTH));
  assign wr_ready_o = !full;
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push       = wr_valid_i && !full && !flush_i;
  assign start_ok   = en_i && (count != '0) && !flush_i;
  assign bit_end    = (tmr == '0);

  // Character length is taken from the configuration at pop time.
  assign head_m = mem[rptr] & (8'hFF >> (2'd3 - bits_i));
  assign thr_p1 = {1'b0, thr_i} + (CW+1)'(1);

  assign tx_o    = tx_q;
  assign busy_o  = (state != S_IDLE);
  assign count_o = count;
  assign event_o = event_q;

  // ---------------- FIFO ----------------
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= wr_data_i;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      event_q <= 1'b0;
    end else begin
      event_q <= pop && ({1'b0, count} == thr_p1);
      if (flush_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bits_left == 3'd0) state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Last stop cycle can chain straight into the next start bit.
        if (bit_end && !stop_left) begin
          if (start_ok) begin
            state_d = S_START;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- shadow frame, bit timer, serial output ----------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tmr       <= '0;
      div_q     <= '0;
      sh        <= '0;
      bits_left <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
      stop_left <= 1'b0;
      tx_q      <= 1'b1;
    end else if (pop) begin
      sh       <= head_m;
      div_q    <= div_i;
      tmr      <= div_i;
      len_q    <= bits_i;
      par_en_q <= par_en_i;
      par_q    <= (^head_m) ^ par_odd_i;
      stop2_q  <= stop2_i;
      tx_q     <= 1'b0;
    end else if (!bit_end) begin
      tmr <= tmr - DIV_WIDTH'(1);
    end else begin
      tmr <= div_q;
      case (state)
        S_START: begin
          tx_q      <= sh[0];
          bits_left <= {1'b1, len_q};  // length-1: 4..7
        end
        S_DATA: begin
          if (bits_left != 3'd0) begin
            sh        <= sh >> 1;
            tx_q      <= sh[1];
            bits_left <= bits_left - 3'd1;
          end else if (par_en_q) begin
            tx_q <= par_q;
          end else begin
            tx_q      <= 1'b1;
            stop_left <= stop2_q;
          end
        end
        S_PARITY: begin
          tx_q      <= 1'b1;
          stop_left <= stop2_q;
        end
        S_STOP: begin
          tx_q      <= 1'b1;
          stop_left <= 1'b0;
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_uart_tx_fifo.sv
module tb_peripheral_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          wr_valid_i;
  logic [7:0]    wr_data_i;
  logic          wr_ready_o;
  logic          en_i;
  logic          flush_i;
  logic [DW-1:0] div_i;
  logic [1:0]    bits_i;
  logic          par_en_i;
  logic          par_odd_i;
  logic          stop2_i;
  logic [CW-1:0] thr_i;
  logic          tx_o;
  logic          busy_o;
  logic [CW-1:0] count_o;
  logic          event_o;

  int n_checks = 0;
  int n_err    = 0;
  int ev_total = 0;
  logic [CW-1:0] ev_lvl = '0;

  peripheral_uart_tx_fifo #(.DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .en_i(en_i), .flush_i(flush_i), .div_i(div_i), .bits_i(bits_i),
    .par_en_i(par_en_i), .par_odd_i(par_odd_i), .stop2_i(stop2_i), .thr_i(thr_i),
    .tx_o(tx_o), .busy_o(busy_o), .count_o(count_o), .event_o(event_o)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (event_o) begin
      ev_total <= ev_total + 1;
      ev_lvl   <= count_o;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: bit list of a frame from the format rules, each bit held div+1 cycles.
  function automatic void exp_frame(input logic [7:0] d, input logic [1:0] b, input logic pe,
                                    input logic po, input logic s2, input int dv,
                                    output logic [127:0] v, output int n);
    int len;
    int ones;
    bit bq[$];
    len  = 5 + int'(b);
    ones = 0;
    bq.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      bq.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) bq.push_back(bit'((ones % 2) == 1) ^ po);
    bq.push_back(1'b1);
    if (s2) bq.push_back(1'b1);
    v = '0;
    n = 0;
    foreach (bq[k]) begin
      for (int r = 0; r <= dv; r++) begin
        v[n] = bq[k];
        n++;
      end
    end
  endfunction

  task automatic set_cfg(input logic [1:0] b, input logic pe, input logic po, input logic s2, input int dv);
    bits_i    = b;
    par_en_i  = pe;
    par_odd_i = po;
    stop2_i   = s2;
    div_i     = DW'(dv);
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    @(negedge CLK);
    wr_valid_i = 1'b0;
  endtask

  // Samples n cycles of tx_o; optionally pulses flush_i after sample flush_at.
  task automatic capture(input int n, input int flush_at, output logic [127:0] v,
                         output int busy_n, output logic [CW-1:0] cnt_flush);
    v = '0;
    busy_n = 0;
    cnt_flush = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      v[i] = tx_o;
      if (busy_o) busy_n++;
      if (flush_at >= 0 && i == flush_at + 1) begin
        cnt_flush = count_o;
        flush_i = 1'b0;
      end
      if (flush_at >= 0 && i == flush_at) flush_i = 1'b1;
    end
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic [1:0] b,
                                input logic pe, input logic po, input logic s2, input int dv);
    logic [127:0] ev, ov;
    int n, bn;
    logic [CW-1:0] cf;
    set_cfg(b, pe, po, s2, dv);
    write_word(d);
    check({tag, " count after write"}, 128'(count_o), 128'(1));
    exp_frame(d, b, pe, po, s2, dv, ev, n);
    capture(n, -1, ov, bn, cf);
    check({tag, " waveform"}, ov, ev);
    check({tag, " busy cycles"}, 128'(bn), 128'(n));
    @(negedge CLK);
    check({tag, " idle after"}, {126'(0), tx_o, busy_o}, 128'b10);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (!tx_o || busy_o) act++;
    end
    check(tag, 128'(act), 128'(0));
  endtask

  initial begin
    logic [7:0]    words [DEPTH+1];
    logic [127:0]  ev, ov;
    int            n, bn, e0;
    logic [CW-1:0] cf;

    RSTN = 1'b0; wr_valid_i = 1'b0; wr_data_i = '0; en_i = 1'b0; flush_i = 1'b0;
    thr_i = '0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 3);

    // reset and idle
    repeat (5) @(negedge CLK);
    check("reset outputs", {123'(0), tx_o, busy_o, wr_ready_o, event_o, (count_o == '0)}, 128'b10101);
    RSTN = 1'b1;
    en_i = 1'b1;
    idle_watch("idle empty fifo", 20);
    check("idle count", 128'(count_o), 128'(0));

    // directed frames
    send_and_check("8N1 A5", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 3);
    send_and_check("7E2 55", 8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 3);
    send_and_check("5O1 1F", 8'h1F, 2'd0, 1'b1, 1'b1, 1'b0, 3);
    send_and_check("div0",   8'hC3, 2'd3, 1'b1, 1'b0, 1'b0, 0);

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      send_and_check($sformatf("rand%0d", k), 8'($urandom), 2'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // FIFO full then back-to-back drain
    en_i = 1'b0;
    foreach (words[i]) words[i] = 8'($urandom);
    for (int i = 0; i <= DEPTH; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = words[i];
      @(negedge CLK);
      if (i == DEPTH - 2) check("ready at 15", 128'(wr_ready_o), 128'(1));
      if (i == DEPTH - 1) check("full 16", {123'(0), wr_ready_o, count_o}, {123'(0), 1'b0, 5'd16});
    end
    wr_valid_i = 1'b0;
    check("17th dropped", 128'(count_o), 128'(16));
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1);
    en_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      exp_frame(words[k], 2'd3, 1'b0, 1'b0, 1'b0, 1, ev, n);
      capture(n, -1, ov, bn, cf);
      check($sformatf("b2b frame %0d", k), ov, ev);
    end
    @(negedge CLK);
    check("b2b drained", {126'(0), busy_o, (count_o == '0)}, 128'b01);

    // watermark
    en_i = 1'b0;
    thr_i = CW'(2);
    e0 = ev_total;
    for (int i = 0; i < 4; i++) write_word(8'(8'h30 + i));
    @(negedge CLK);
    check("no event on writes", 128'(ev_total - e0), 128'(0));
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 0);
    en_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_frame(8'(8'h30 + k), 2'd3, 1'b0, 1'b0, 1'b0, 0, ev, n);
      capture(n, -1, ov, bn, cf);
      check($sformatf("wm frame %0d", k), ov, ev);
    end
    repeat (2) @(negedge CLK);
    check("event pulses", 128'(ev_total - e0), 128'(1));
    check("event level", 128'(ev_lvl), 128'(2));

    // flush mid-frame
    en_i = 1'b0;
    e0 = ev_total;
    thr_i = CW'(0);
    write_word(8'h96); write_word(8'h11); write_word(8'h22);
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 3);
    en_i = 1'b1;
    exp_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 3, ev, n);
    capture(n, 8, ov, bn, cf);
    check("flush count 0", 128'(cf), 128'(0));
    check("flush frame completes", ov, ev);
    idle_watch("after flush idle", 30);
    check("no event on flush", 128'(ev_total - e0), 128'(0));

    // asynchronous reset mid-frame
    en_i = 1'b0;
    write_word(8'h5A); write_word(8'h00);
    en_i = 1'b1;
    repeat (7) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("async rst outputs", {123'(0), tx_o, busy_o, wr_ready_o, event_o, (count_o == '0)}, 128'b10101);
    @(negedge CLK);
    RSTN = 1'b1;
    idle_watch("after reset idle", 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
